vga_timing_decoder: RTL and testbench
=====================================

# vga_timing_decoder

Receive-side counterpart of the monitor sync generator. The block watches an incoming active-low Hsynch/Vsynch pair on the pixel clock and recovers the pixel coordinates. It also measures line length and frame height, and reports lock once the measured timing matches the configured mode. It sits in the capture/loopback path, where its PixelRow/PixelCol drive a frame-buffer writer or checker.

## Interface
- H_TOTAL, 800: expected clocks per line.
- V_TOTAL, 525: expected lines per frame.
- H_ACTIVE, 640: visible columns.
- V_ACTIVE, 480: visible rows.
- H_BP, 43: clocks from the Hsynch rising edge to column 0.
- V_BP, 31: lines from the Vsynch rising edge to row 0.
- LOCK_FRAMES, 2: consecutive good frames required for lock (1..7).
- SynchClock  in  1  pixel clock; all logic on its rising edge.
- Reset  in  1  asynchronous, active-high.
- Hsynch  in  1  horizontal sync, active low.
- Vsynch  in  1  vertical sync, active low.
- PixelCol  out  10  recovered column, 0..H_ACTIVE-1; 0 outside the active region.
- PixelRow  out  10  recovered row, 0..V_ACTIVE-1; 0 outside the active region.
- Active  out  1  high while PixelCol/PixelRow address a visible pixel.
- FrameStart  out  1  one-cycle pulse when the row counter restarts.
- LineLength  out  10  last measured clocks per line.
- FrameLines  out  10  last measured lines per frame.
- Locked  out  1  timing matches the parameters.
- SyncError  out  1  one-cycle pulse on a measurement mismatch.

## Operation
- Edge detect: registered copies hs_q/vs_q. A rising edge is "previous 0, current 1" (end of the sync pulse).
- hcnt (10 b): cleared to 0 on an hs rising edge; otherwise increments, saturating at 1023. On an hs rising edge, LineLength <= hcnt + 1, saturating at 1023.
- vcnt (10 b): increments on each hs rising edge, saturating at 1023. A vs rising edge arms a flag. The next hs rising edge then clears vcnt to 0, captures FrameLines <= vcnt + 1, pulses FrameStart, and clears the flag.
- If the hs and vs rising edges occur in the same cycle, the vs edge arms the flag first, so that same hs edge restarts the frame.
- Column: Active_h when H_BP <= hcnt < H_BP + H_ACTIVE; PixelCol = hcnt - H_BP.
- Row: Active_v when V_BP <= vcnt < V_BP + V_ACTIVE; PixelRow = vcnt - V_BP.
- Active = Active_h & Active_v & Locked. When Active is low, both coordinates are forced to 0.
- FSM, 2-bit state in the package:
  - SEARCH → TRACK on the first FrameStart.
  - TRACK: on each FrameStart, the frame is good when every LineLength captured during it equals H_TOTAL and FrameLines equals V_TOTAL. A good frame increments goodcnt; goodcnt reaching LOCK_FRAMES moves to LOCKED.
  - TRACK or LOCKED, any mismatch (bad LineLength at any hs edge, or bad FrameLines): pulse SyncError, clear goodcnt, go to TRACK.
  - Any state: hcnt saturating at 1023 (loss of Hsynch) → SEARCH, with a SyncError pulse.
- Locked = (state == LOCKED).

## Timing
- Reset values: all counters 0; LineLength and FrameLines 0; state SEARCH; hs_q and vs_q 1. Every output reads 0 during reset.
- Latency without the synchronizer: an Hsynch rising edge sampled at cycle N gives hcnt = 0 at cycle N+1. With the synchronizer it is N+3.
- Outputs are registered and change only on SynchClock.
- FrameStart and SyncError are exactly one cycle wide.
- Reset asserted mid-frame clears state immediately. Lock needs LOCK_FRAMES + 1 FrameStarts after release.

## Configuration
- VGA_TIMING_DECODER_SYNC2FF_EN defined: Hsynch and Vsynch each pass through a 2-flop synchronizer (reset value 1) before edge detect, for asynchronous sources.
- Not defined: the inputs feed edge detect directly, for same-clock loopback. All other behaviour is identical apart from the 2-cycle latency difference.

## Structure
- Package vga_timing_pkg: state enum (SEARCH, TRACK, LOCKED), 640x480@60 default constants shared with the generator, and a 10-bit coordinate typedef.
- One sub-module, sync_edge_detect: optional synchronizer plus rising-edge pulse, instantiated once for Hsynch and once for Vsynch.

## Test plan
- Same-clock loopback from the sync generator at defaults:
  - Locked rises after the 3rd FrameStart.
  - LineLength = 800, FrameLines = 525.
  - At the 1st active pixel, PixelCol = 0 and PixelRow = 0; the final active pixel is 639/479.
- Line of 799 clocks injected while locked: SyncError pulses once at that hs edge, Locked drops, and relock occurs after 2 good frames.
- Hsynch held high: after 1024 clocks the block is in SEARCH, with a SyncError pulse, Active = 0 and Locked = 0.
- Reset pulsed mid-line at hcnt = 300: all outputs are 0 next cycle, and the relock sequence is as in the first case.
- Hs and vs rising edges in the same cycle: FrameStart fires on that edge and vcnt = 0 next cycle.
- With the macro defined: hcnt = 0 occurs 3 cycles after the Hsynch rise, and the loopback test still locks.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared types and 640x480@60 default timing for the VGA sync generator/decoder pair.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } dec_state_t;

  typedef logic [9:0] coord_t;

  localparam int DEF_H_TOTAL     = 800;
  localparam int DEF_V_TOTAL     = 525;
  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_H_BP        = 43;
  localparam int DEF_V_BP        = 31;
  localparam int DEF_LOCK_FRAMES = 2;

  localparam coord_t CNT_MAX = 10'h3FF;

  function automatic coord_t sat_inc(input coord_t v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Rising-edge (end of active-low sync) detector; VGA_TIMING_DECODER_SYNC2FF_EN adds
// a 2-flop synchronizer ahead of the edge register for asynchronous sources.
module sync_edge_detect (
  input  logic SynchClock,
  input  logic Reset,
  input  logic sync_n,
  output logic rise
);

  logic level;
  logic level_q;

`ifdef VGA_TIMING_DECODER_SYNC2FF_EN
  logic [1:0] meta;

  always_ff @(posedge SynchClock or posedge Reset) begin
    if (Reset) meta <= 2'b11;
    else       meta <= {meta[0], sync_n};
  end

  assign level = meta[1];
`else
  assign level = sync_n;
`endif

  always_ff @(posedge SynchClock or posedge Reset) begin
    if (Reset) level_q <= 1'b1;
    else       level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/vga_timing_decoder.sv
// Recovers pixel coordinates from an incoming Hsynch/Vsynch pair, measures line/frame
// timing and reports lock. VGA_TIMING_DECODER_SYNC2FF_EN selects synchronized inputs.
module vga_timing_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_BP        = DEF_V_BP,
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic   SynchClock,
  input  logic   Reset,
  input  logic   Hsynch,
  input  logic   Vsynch,
  output coord_t PixelCol,
  output coord_t PixelRow,
  output logic   Active,
  output logic   FrameStart,
  output coord_t LineLength,
  output coord_t FrameLines,
  output logic   Locked,
  output logic   SyncError
);

  localparam coord_t     H_TOT  = coord_t'(H_TOTAL);
  localparam coord_t     V_TOT  = coord_t'(V_TOTAL);
  localparam coord_t     H_LO   = coord_t'(H_BP);
  localparam coord_t     H_HI   = coord_t'(H_BP + H_ACTIVE);
  localparam coord_t     V_LO   = coord_t'(V_BP);
  localparam coord_t     V_HI   = coord_t'(V_BP + V_ACTIVE);
  localparam logic [2:0] LOCK_N = 3'(LOCK_FRAMES);

  logic       hs_rise, vs_rise;
  coord_t     hcnt, vcnt;
  logic       armed;
  logic [2:0] goodcnt;
  logic       line_err;
  dec_state_t state;

  sync_edge_detect u_hs (
    .SynchClock (SynchClock),
    .Reset      (Reset),
    .sync_n     (Hsynch),
    .rise       (hs_rise)
  );

  sync_edge_detect u_vs (
    .SynchClock (SynchClock),
    .Reset      (Reset),
    .sync_n     (Vsynch),
    .rise       (vs_rise)
  );

  coord_t     len_meas, frm_meas;
  logic       new_frame, hs_lost, line_bad, frame_bad, frame_good;
  logic       act_h, act_v, act;
  logic [2:0] good_next;

  // A vs edge in the same cycle as the hs edge counts as already armed.
  assign new_frame  = hs_rise & (armed | vs_rise);
  assign len_meas   = sat_inc(hcnt);
  assign frm_meas   = sat_inc(vcnt);
  assign hs_lost    = ~hs_rise & (hcnt == CNT_MAX - 10'd1);
  assign line_bad   = hs_rise & (len_meas != H_TOT);
  assign frame_bad  = new_frame & (frm_meas != V_TOT);
  assign frame_good = new_frame & ~frame_bad & ~line_bad & ~line_err;
  assign good_next  = goodcnt + 3'd1;

  assign act_h = (hcnt >= H_LO) && (hcnt < H_HI);
  assign act_v = (vcnt >= V_LO) && (vcnt < V_HI);
  assign act   = act_h & act_v & (state == LOCKED);

  always_ff @(posedge SynchClock or posedge Reset) begin
    if (Reset) begin
      hcnt       <= '0;
      vcnt       <= '0;
      armed      <= 1'b0;
      LineLength <= '0;
      FrameLines <= '0;
      FrameStart <= 1'b0;
    end else begin
      FrameStart <= new_frame;
      if (hs_rise) begin
        hcnt       <= '0;
        LineLength <= len_meas;
      end else begin
        hcnt <= sat_inc(hcnt);
      end
      if (new_frame) begin
        vcnt       <= '0;
        FrameLines <= frm_meas;
        armed      <= 1'b0;
      end else begin
        if (hs_rise) vcnt  <= sat_inc(vcnt);
        if (vs_rise) armed <= 1'b1;
      end
    end
  end

  // line_err remembers an already-reported bad line so that frame is not counted good.
  always_ff @(posedge SynchClock or posedge Reset) begin
    if (Reset) begin
      state     <= SEARCH;
      goodcnt   <= '0;
      line_err  <= 1'b0;
      SyncError <= 1'b0;
    end else begin
      SyncError <= 1'b0;
      if (new_frame)     line_err <= 1'b0;
      else if (line_bad) line_err <= 1'b1;

      if (hs_lost) begin
        state     <= SEARCH;
        goodcnt   <= '0;
        SyncError <= 1'b1;
      end else begin
        case (state)
          SEARCH: begin
            if (new_frame) begin
              state   <= TRACK;
              goodcnt <= '0;
            end
          end
          TRACK, LOCKED: begin
            if (line_bad || frame_bad) begin
              SyncError <= 1'b1;
              goodcnt   <= '0;
              state     <= TRACK;
            end else if (frame_good && state == TRACK) begin
              goodcnt <= good_next;
              if (good_next >= LOCK_N) state <= LOCKED;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  always_ff @(posedge SynchClock or posedge Reset) begin
    if (Reset) begin
      Active   <= 1'b0;
      PixelCol <= '0;
      PixelRow <= '0;
    end else begin
      Active   <= act;
      PixelCol <= act ? hcnt - H_LO : '0;
      PixelRow <= act ? vcnt - V_LO : '0;
    end
  end

  assign Locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench: scaled 40x20 timing (hsync low 6 clocks, vsync low 2 lines).
module tb_vga_timing_decoder;

`ifdef VGA_TIMING_DECODER_SYNC2FF_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       SynchClock = 1'b0;
  logic       Reset, Hsynch, Vsynch;
  logic [9:0] PixelCol, PixelRow, LineLength, FrameLines;
  logic       Active, FrameStart, Locked, SyncError;

  vga_timing_decoder #(
    .H_TOTAL(40), .V_TOTAL(20), .H_ACTIVE(16), .V_ACTIVE(8),
    .H_BP(5), .V_BP(3), .LOCK_FRAMES(2)
  ) dut (
    .SynchClock (SynchClock),
    .Reset      (Reset),
    .Hsynch     (Hsynch),
    .Vsynch     (Vsynch),
    .PixelCol   (PixelCol),
    .PixelRow   (PixelRow),
    .Active     (Active),
    .FrameStart (FrameStart),
    .LineLength (LineLength),
    .FrameLines (FrameLines),
    .Locked     (Locked),
    .SyncError  (SyncError)
  );

  always #5 SynchClock = ~SynchClock;

  int   checks = 0, failures = 0;
  int   fs_cnt = 0, se_cnt = 0, lock_fs = -1, act_n = 0;
  int   first_col, first_row, last_col, last_row;
  int   fs_b, se_b;
  logic lk_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sample();
    if (FrameStart === 1'b1) fs_cnt++;
    if (SyncError === 1'b1) se_cnt++;
    if (Locked === 1'b1 && !lk_prev) lock_fs = fs_cnt;
    lk_prev = (Locked === 1'b1);
    if (Active === 1'b1) begin
      if (act_n == 0) begin
        first_col = int'(PixelCol);
        first_row = int'(PixelRow);
      end
      last_col = int'(PixelCol);
      last_row = int'(PixelRow);
      act_n++;
    end
  endtask

  task automatic tick(input logic h, input logic v);
    @(negedge SynchClock);
    sample();
    Hsynch = h;
    Vsynch = v;
  endtask

  task automatic line(input int len, input int vrise);
    for (int c = 0; c < len; c++) tick(c >= 6, c >= vrise);
  endtask

  task automatic frame(input int short_l);
    for (int l = 0; l < 20; l++) line((l == short_l) ? 39 : 40, (l < 2) ? 99 : 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_col"}, PixelCol, 0);
    chk({tag, "_row"}, PixelRow, 0);
    chk({tag, "_active"}, Active, 0);
    chk({tag, "_fs"}, FrameStart, 0);
    chk({tag, "_linelen"}, LineLength, 0);
    chk({tag, "_frmlines"}, FrameLines, 0);
    chk({tag, "_locked"}, Locked, 0);
    chk({tag, "_syncerr"}, SyncError, 0);
  endtask

  initial begin
    Reset = 1'b1; Hsynch = 1'b1; Vsynch = 1'b1;
    repeat (3) @(negedge SynchClock);
    chk_all_zero("reset");
    Reset = 1'b0;
    repeat (5) tick(1'b1, 1'b1);

    // Acquisition: lock on the third FrameStart
    act_n = 0;
    frame(-1);
    frame(-1);
    chk("no_active_before_lock", act_n, 0);
    act_n = 0;
    frame(-1);
    chk("lock_at_fs", lock_fs, 3);
    chk("linelength", LineLength, 40);
    chk("framelines", FrameLines, 20);
    chk("active_count", act_n, 128);
    chk("first_col", first_col, 0);
    chk("first_row", first_row, 0);
    chk("last_col", last_col, 15);
    chk("last_row", last_row, 7);
    fs_b = fs_cnt;
    frame(-1);
    chk("fs_per_frame", fs_cnt - fs_b, 1);
    chk("locked_steady", Locked, 1);

    // One short line while locked
    se_b = se_cnt;
    frame(8);
    chk("short_line_syncerr", se_cnt - se_b, 1);
    chk("short_line_unlock", Locked, 0);
    frame(-1);
    frame(-1);
    chk("relock_not_yet", Locked, 0);
    frame(-1);
    chk("relock", Locked, 1);
    chk("short_line_syncerr_total", se_cnt - se_b, 1);

    // Reset mid-line while locked
    for (int l = 0; l < 5; l++) line(40, (l < 2) ? 99 : 0);
    for (int c = 0; c < 20; c++) tick(c >= 6, 1'b1);
    Reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    tick(1'b1, 1'b1);
    Reset = 1'b0;
    for (int c = 21; c < 40; c++) tick(1'b1, 1'b1);
    for (int l = 6; l < 20; l++) line(40, 0);
    fs_b = fs_cnt;
    frame(-1);
    frame(-1);
    frame(-1);
    chk("reset_relock_fs", lock_fs - fs_b, 3);
    chk("reset_relock", Locked, 1);

    // Coincident hs/vs rising edges
    se_b = se_cnt;
    line(40, 99);
    line(40, 99);
    for (int c = 0; c <= 6 + LAT; c++) tick(c >= 6, c >= 6);
    chk("coinc_fs_early", FrameStart, 0);
    tick(1'b1, 1'b1);
    chk("coinc_fs", FrameStart, 1);
    chk("coinc_vcnt", dut.vcnt, 0);
    chk("coinc_hcnt", dut.hcnt, 0);
    for (int c = 8 + LAT; c < 40; c++) tick(1'b1, 1'b1);
    for (int l = 3; l < 20; l++) line(40, 0);
    chk("coinc_locked", Locked, 1);
    chk("coinc_framelines", FrameLines, 20);
    chk("coinc_no_syncerr", se_cnt - se_b, 0);

    // Hsynch held high: saturation forces SEARCH
    se_b = se_cnt;
    repeat (980) tick(1'b1, 1'b1);
    chk("hold_syncerr_early", se_cnt - se_b, 0);
    chk("hold_locked_early", Locked, 1);
    repeat (50) tick(1'b1, 1'b1);
    chk("hold_syncerr", se_cnt - se_b, 1);
    chk("hold_locked", Locked, 0);
    chk("hold_active", Active, 0);
    chk("hold_col", PixelCol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
